// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_e;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_DIV_115200_100M = 868;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: synchronous enqueue/dequeue, extra pointer bit distinguishes full from empty.
module uart_rx_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] deq_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             deq_fire;
  logic             enq_fire;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign deq_fire = deq && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign enq_fire = enq && (!full || deq_fire);
  assign deq_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: line synchronizer, mid-bit sampling FSM, shift register and RX FIFO.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        io_rx,
  input  logic [DIV_W-1:0]            io_baud_div,
  input  logic                        io_deq_ready,
  output logic                        io_deq_valid,
  output logic [7:0]                  io_deq_bits,
  output logic [$clog2(FIFO_DEPTH):0] io_count,
  output logic                        io_frame_err,
  output logic                        io_overrun,
  input  logic                        io_err_clr,
  output logic                        io_rx_irq
);

  localparam logic [DIV_W-1:0] ONE = 1;
  localparam int unsigned      BW  = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0]    BIT_LAST = BW'(UART_DATA_BITS - 1);

  logic                      rx_meta;
  logic                      rx;
  rx_state_e                 state;
  logic [DIV_W-1:0]          cnt;
  logic [DIV_W-1:0]          div_q;
  logic [DIV_W-1:0]          half_m1;
  logic [DIV_W-1:0]          full_m1;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      push;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      deq_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= io_rx;
      rx      <= rx_meta;
    end
  end

  assign half_m1  = (div_q >> 1) - ONE;
  assign full_m1  = div_q - ONE;
  assign deq_fire = io_deq_ready && !fifo_empty;
  assign push     = (state == STOP) && (cnt == full_m1) && rx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      div_q        <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      io_frame_err <= 1'b0;
      io_overrun   <= 1'b0;
    end else begin
      // Clear first so an error event later in this block takes priority.
      if (io_err_clr) begin
        io_frame_err <= 1'b0;
        io_overrun   <= 1'b0;
      end
      cnt <= cnt + ONE;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) begin
            state <= START;
            div_q <= io_baud_div;
          end
        end
        START: begin
          if (cnt == half_m1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == full_m1) begin
            cnt     <= '0;
            shift   <= {rx, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == full_m1) begin
            cnt <= '0;
            if (rx) begin
              state <= IDLE;
              if (fifo_full && !deq_fire) io_overrun <= 1'b1;
            end else begin
              io_frame_err <= 1'b1;
              state        <= BRK;
            end
          end
        end
        BRK: begin
          cnt <= '0;
          if (rx) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .enq      (push),
    .enq_data (shift),
    .deq      (io_deq_ready),
    .deq_data (io_deq_bits),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (io_count)
  );

  assign io_deq_valid = !fifo_empty;
  assign io_rx_irq    = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: table of frames plus timed corner-case sequences.
module tb_uart_rx_deser;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_rx = 1'b1;
  logic [15:0] io_baud_div = 16'd868;
  logic        io_deq_ready = 1'b0;
  logic        io_err_clr = 1'b0;
  logic        io_deq_valid;
  logic [7:0]  io_deq_bits;
  logic [3:0]  io_count;
  logic        io_frame_err;
  logic        io_overrun;
  logic        io_rx_irq;

  always #5 clock = ~clock;

  uart_rx_deser #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_rx        (io_rx),
    .io_baud_div  (io_baud_div),
    .io_deq_ready (io_deq_ready),
    .io_deq_valid (io_deq_valid),
    .io_deq_bits  (io_deq_bits),
    .io_count     (io_count),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun),
    .io_err_clr   (io_err_clr),
    .io_rx_irq    (io_rx_irq)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  logic [7:0]  got[$];
  int unsigned got_t[$];
  int          ferr_rises = 0;
  logic        ferr_prev = 1'b0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (io_deq_valid && io_deq_ready) begin
      got.push_back(io_deq_bits);
      got_t.push_back(cyc);
    end
    if (io_frame_err && !ferr_prev) ferr_rises++;
    ferr_prev = io_frame_err;
  end

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned div);
    io_rx = 1'b0;
    start_cyc = cyc;
    repeat (div) tick();
    for (int i = 0; i < 8; i++) begin
      io_rx = d[i];
      repeat (div) tick();
    end
    io_rx = stop;
    repeat (div) tick();
  endtask

  task automatic wait_byte(input int unsigned limit);
    for (int unsigned k = 0; k < limit && got.size() == 0; k++) tick();
  endtask

  task automatic expect_byte(input string name, input logic [7:0] exp, input int unsigned lat_max);
    logic [7:0]  b;
    int unsigned t;
    if (got.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no byte dequeued, expected 0x%0h", name, exp);
    end else begin
      b = got.pop_front();
      t = got_t.pop_front();
      check(name, 32'(b), 32'(exp));
      if (lat_max != 0) check({name, " latency_ok"}, 32'((t - start_cyc) <= lat_max), 32'd1);
    end
  endtask

  // Pulse one control input during the cycle whose edge samples the stop bit.
  task automatic pulse_at_stop(input int unsigned div, input bit sel_clr);
    repeat (2 + (div >> 1) + 9 * div) tick();
    if (sel_clr) io_err_clr = 1'b1;
    else         io_deq_ready = 1'b1;
    tick();
    io_err_clr   = 1'b0;
    io_deq_ready = 1'b0;
  endtask

  task automatic clear_errs();
    io_err_clr = 1'b1;
    tick();
    io_err_clr = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned div;
    logic        exp_byte;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h55, 1'b1, 868, 1'b1, 1'b0};
    vecs[1] = '{8'hAA, 1'b1, 868, 1'b1, 1'b0};
    vecs[2] = '{8'h33, 1'b1, 868, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 16,  1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 16,  1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 4,   1'b1, 1'b0};
    vecs[6] = '{8'hC6, 1'b1, 5,   1'b1, 1'b0};
    vecs[7] = '{8'h96, 1'b0, 16,  1'b0, 1'b1};
    vecs[8] = '{8'h81, 1'b1, 7,   1'b1, 1'b0};

    repeat (3) tick();
    check("reset deq_valid", 32'(io_deq_valid), 32'd0);
    check("reset deq_bits", 32'(io_deq_bits), 32'd0);
    check("reset count", 32'(io_count), 32'd0);
    check("reset frame_err", 32'(io_frame_err), 32'd0);
    check("reset overrun", 32'(io_overrun), 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Table of single frames, consumer always ready.
    io_deq_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      io_baud_div = 16'(vecs[i].div);
      tick();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].div);
      io_rx = 1'b1;
      wait_byte(2 * vecs[i].div);
      if (vecs[i].exp_byte)
        expect_byte($sformatf("vec%0d byte", i), vecs[i].data,
                    9 * vecs[i].div + (vecs[i].div >> 1) + 4);
      else
        check($sformatf("vec%0d no byte", i), 32'(got.size()), 32'd0);
      check($sformatf("vec%0d frame_err", i), 32'(io_frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d overrun", i), 32'(io_overrun), 32'd0);
      if (vecs[i].exp_ferr) begin
        clear_errs();
        check($sformatf("vec%0d frame_err cleared", i), 32'(io_frame_err), 32'd0);
      end
    end

    // Short low glitch is rejected at the mid-start sample.
    io_baud_div = 16'd868;
    tick();
    io_rx = 1'b0;
    repeat (300) tick();
    io_rx = 1'b1;
    repeat (1000) tick();
    check("glitch no byte", 32'(got.size()), 32'd0);
    check("glitch frame_err", 32'(io_frame_err), 32'd0);
    send_frame(8'hA5, 1'b1, 868);
    io_rx = 1'b1;
    wait_byte(2000);
    expect_byte("after glitch", 8'hA5, 9 * 868 + 434 + 4);

    // Bad stop bit followed by a long break: one frame error, no bytes.
    io_baud_div = 16'd16;
    tick();
    begin
      int ferr0;
      ferr0 = ferr_rises;
      send_frame(8'hAA, 1'b0, 16);
      repeat (20 * 16) tick();
      io_rx = 1'b1;
      repeat (64) tick();
      check("break ferr events", 32'(ferr_rises - ferr0), 32'd1);
    end
    check("break frame_err", 32'(io_frame_err), 32'd1);
    check("break no byte", 32'(got.size()), 32'd0);
    check("break count", 32'(io_count), 32'd0);
    send_frame(8'h0F, 1'b1, 16);
    io_rx = 1'b1;
    wait_byte(64);
    expect_byte("after break", 8'h0F, 0);
    clear_errs();
    check("frame_err cleared", 32'(io_frame_err), 32'd0);

    // Overflow: nine back-to-back bytes with no consumer; clear collides with the overrun set.
    io_deq_ready = 1'b0;
    repeat (4) tick();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 16);
    check("fill count", 32'(io_count), 32'd8);
    fork
      send_frame(8'h09, 1'b1, 16);
      pulse_at_stop(16, 1'b1);
    join
    io_rx = 1'b1;
    repeat (32) tick();
    check("overflow count", 32'(io_count), 32'd8);
    check("overrun set wins", 32'(io_overrun), 32'd1);
    check("overflow irq", 32'(io_rx_irq), 32'd1);
    io_deq_ready = 1'b1;
    repeat (16) tick();
    io_deq_ready = 1'b0;
    check("drain size", 32'(got.size()), 32'd8);
    for (int i = 1; i <= 8; i++) expect_byte($sformatf("drain %0d", i), 8'(i), 0);
    check("drained valid", 32'(io_deq_valid), 32'd0);
    clear_errs();
    check("overrun cleared", 32'(io_overrun), 32'd0);

    // Full FIFO with a dequeue exactly in the stop-sample cycle.
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 16);
    check("refill count", 32'(io_count), 32'd8);
    fork
      send_frame(8'h19, 1'b1, 16);
      pulse_at_stop(16, 1'b0);
    join
    io_rx = 1'b1;
    repeat (8) tick();
    check("simul count", 32'(io_count), 32'd8);
    check("simul overrun", 32'(io_overrun), 32'd0);
    expect_byte("simul popped", 8'h11, 0);
    io_deq_ready = 1'b1;
    repeat (16) tick();
    io_deq_ready = 1'b0;
    for (int i = 0; i < 8; i++) expect_byte($sformatf("simul drain %0d", i), 8'h12 + 8'(i), 0);

    // Reset during data bit 4 with a byte already queued.
    send_frame(8'h77, 1'b1, 16);
    io_rx = 1'b1;
    repeat (8) tick();
    check("pre-reset count", 32'(io_count), 32'd1);
    fork
      send_frame(8'hC3, 1'b1, 16);
      begin
        repeat (3 + 8 + 4 * 16 + 8) tick();
        reset_n = 1'b0;
        #1;
        check("midreset valid", 32'(io_deq_valid), 32'd0);
        check("midreset bits", 32'(io_deq_bits), 32'd0);
        check("midreset count", 32'(io_count), 32'd0);
        check("midreset irq", 32'(io_rx_irq), 32'd0);
      end
    join
    io_rx = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (40) tick();
    check("post-reset no byte", 32'(io_count), 32'd0);
    io_deq_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 16);
    io_rx = 1'b1;
    wait_byte(64);
    expect_byte("post-reset byte", 8'h3C, 9 * 16 + 8 + 4);
    io_baud_div = 16'd434;
    tick();
    send_frame(8'hE7, 1'b1, 434);
    io_rx = 1'b1;
    wait_byte(1000);
    expect_byte("div434 byte", 8'hE7, 9 * 434 + 217 + 4);
    check("final frame_err", 32'(io_frame_err), 32'd0);
    check("final overrun", 32'(io_overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
